// File: rtl/display_scan_if.sv
// Host-side signals of the six-digit multiplexed display scanner.
// The host drives enable/load/in0..in5; the scanner drives seg/an/digit_idx/frame_done.
interface display_scan_if;
    logic       enable;
    logic       load;
    logic [3:0] in0;
    logic [3:0] in1;
    logic [3:0] in2;
    logic [3:0] in3;
    logic [3:0] in4;
    logic [3:0] in5;
    logic [6:0] seg;
    logic [5:0] an;
    logic [2:0] digit_idx;
    logic       frame_done;

    modport master (
        output enable, load, in0, in1, in2, in3, in4, in5,
        input  seg, an, digit_idx, frame_done
    );

    modport slave (
        input  enable, load, in0, in1, in2, in3, in4, in5,
        output seg, an, digit_idx, frame_done
    );
endinterface

// File: rtl/display_scan.sv
// Six-digit active-low 7-segment scanner with blanking gaps, double-buffered
// digit banks (tear-free updates at frame boundaries) and leading-zero suppression.
module display_scan #(
    parameter int unsigned DWELL      = 1000,
    parameter int unsigned BLANK_GAP  = 2,
    parameter bit          LEAD_BLANK = 1'b1
) (
    input  logic          clock,
    input  logic          reset,
    display_scan_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } state_e;

    localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);
    localparam logic [7:0]  GAP_LAST   = 8'((BLANK_GAP == 0) ? 0 : BLANK_GAP - 1);

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    state_e          state_q, state_d;
    logic [15:0]     dwell_q, dwell_d;
    logic [7:0]      gap_q, gap_d;
    logic [2:0]      digit_q, digit_d;
    logic [5:0][3:0] pend_q, pend_d;
    logic            pend_vld_q, pend_vld_d;
    logic [5:0][3:0] disp_q, disp_d;
    logic [5:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            fdone_q, fdone_d;

    logic [5:0][3:0] in_bank;
    logic            swap;
    logic [2:0]      hi_digit;
    logic [3:0]      cur_nib;

    assign in_bank = {bus.in5, bus.in4, bus.in3, bus.in2, bus.in1, bus.in0};

    // fdone_q marks the last SHOW cycle of digit 5, i.e. the frame boundary.
    assign swap = (state_q == IDLE) || fdone_q;

    always_comb begin
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        disp_d     = disp_q;
        if (swap) begin
            if (bus.load) begin
                disp_d     = in_bank;
                pend_d     = in_bank;
                pend_vld_d = 1'b0;
            end else if (pend_vld_q) begin
                disp_d     = pend_q;
                pend_vld_d = 1'b0;
            end
        end else if (bus.load) begin
            pend_d     = in_bank;
            pend_vld_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        gap_d   = gap_q;
        digit_d = digit_q;
        if (!bus.enable) begin
            state_d = IDLE;
            dwell_d = '0;
            gap_d   = '0;
            digit_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    dwell_d = '0;
                    gap_d   = '0;
                    digit_d = '0;
                    state_d = (BLANK_GAP == 0) ? SHOW : BLANK;
                end
                BLANK: begin
                    if (gap_q == GAP_LAST) begin
                        state_d = SHOW;
                        gap_d   = '0;
                        dwell_d = '0;
                    end else begin
                        gap_d = gap_q + 8'd1;
                    end
                end
                SHOW: begin
                    if (dwell_q == DWELL_LAST) begin
                        dwell_d = '0;
                        gap_d   = '0;
                        digit_d = (digit_q == 3'd5) ? 3'd0 : digit_q + 3'd1;
                        state_d = (BLANK_GAP == 0) ? SHOW : BLANK;
                    end else begin
                        dwell_d = dwell_q + 16'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        hi_digit = '0;
        for (int unsigned i = 1; i < 6; i++) begin
            if (disp_d[i] != 4'h0) hi_digit = 3'(i);
        end
    end

    always_comb begin
        case (digit_d)
            3'd0:    cur_nib = disp_d[0];
            3'd1:    cur_nib = disp_d[1];
            3'd2:    cur_nib = disp_d[2];
            3'd3:    cur_nib = disp_d[3];
            3'd4:    cur_nib = disp_d[4];
            3'd5:    cur_nib = disp_d[5];
            default: cur_nib = '0;
        endcase
    end

    // Outputs are decoded from next-cycle state so they register alongside it.
    always_comb begin
        an_d    = '1;
        seg_d   = '1;
        fdone_d = 1'b0;
        if (state_d == SHOW) begin
            an_d = ~(6'b000001 << digit_d);
            if (!(LEAD_BLANK && (digit_d > hi_digit))) seg_d = hex7(cur_nib);
            fdone_d = (digit_d == 3'd5) && (dwell_d == DWELL_LAST);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            dwell_q    <= '0;
            gap_q      <= '0;
            digit_q    <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            disp_q     <= '0;
            an_q       <= '1;
            seg_q      <= '1;
            fdone_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            dwell_q    <= dwell_d;
            gap_q      <= gap_d;
            digit_q    <= digit_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            disp_q     <= disp_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            fdone_q    <= fdone_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.digit_idx  = digit_q;
    assign bus.frame_done = fdone_q;

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan with DWELL=4, BLANK_GAP=1, LEAD_BLANK=1:
// a table of digit patterns with expected segment codes, plus multi-frame sequences.
module tb_display_scan;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    display_scan_if bus();

    display_scan #(
        .DWELL      (4),
        .BLANK_GAP  (1),
        .LEAD_BLANK (1'b1)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [23:0]     digits;
        logic [5:0][6:0] seg;
    } vec_t;

    vec_t vecs[6];

    localparam logic [5:0][6:0] SEG_1234 = {7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19};
    localparam logic [5:0][6:0] SEG_8    = {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    localparam logic [5:0][6:0] SEG_ZERO = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inputs(input logic [23:0] v);
        {bus.in5, bus.in4, bus.in3, bus.in2, bus.in1, bus.in0} = v;
    endtask

    task automatic chk_idle(input string name);
        chk({name, ".an"}, 32'(bus.an), 32'h3F);
        chk({name, ".seg"}, 32'(bus.seg), 32'h7F);
        chk({name, ".idx"}, 32'(bus.digit_idx), 32'd0);
        chk({name, ".fd"}, 32'(bus.frame_done), 32'd0);
    endtask

    task automatic load_idle(input logic [23:0] v);
        set_inputs(v);
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
    endtask

    // Each digit slot is 5 cycles: one blank then four shown; frame_done on cycle 30.
    task automatic run_frame(input string name, input logic [5:0][6:0] exps,
                             input int unsigned n, input int unsigned load_at,
                             input logic [23:0] lval);
        int unsigned pos, d, ph;
        logic [5:0]  e_an;
        logic [6:0]  e_seg;
        for (int unsigned c = 1; c <= n; c++) begin
            if (c == load_at) begin
                set_inputs(lval);
                bus.load = 1'b1;
            end else begin
                bus.load = 1'b0;
            end
            step();
            pos   = c - 1;
            d     = pos / 5;
            ph    = pos % 5;
            e_an  = (ph == 0) ? 6'h3F : ~(6'b000001 << d);
            e_seg = (ph == 0) ? 7'h7F : exps[d];
            chk($sformatf("%s.c%0d.an", name, c), 32'(bus.an), 32'(e_an));
            chk($sformatf("%s.c%0d.seg", name, c), 32'(bus.seg), 32'(e_seg));
            chk($sformatf("%s.c%0d.idx", name, c), 32'(bus.digit_idx), d);
            chk($sformatf("%s.c%0d.fd", name, c), 32'(bus.frame_done), (c == 30) ? 32'd1 : 32'd0);
        end
        bus.load = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        vecs[0] = '{24'h001234, SEG_1234};
        vecs[1] = '{24'h888888, SEG_8};
        vecs[2] = '{24'h000000, SEG_ZERO};
        vecs[3] = '{24'h0C0E05, {7'h7F, 7'h46, 7'h40, 7'h06, 7'h40, 7'h12}};
        vecs[4] = '{24'h67890F, {7'h02, 7'h78, 7'h00, 7'h10, 7'h40, 7'h0E}};
        vecs[5] = '{24'hABCD00, {7'h08, 7'h03, 7'h46, 7'h21, 7'h40, 7'h40}};

        rst        = 1'b1;
        bus.enable = 1'b0;
        bus.load   = 1'b0;
        set_inputs('0);
        step();
        step();
        chk_idle("reset");
        rst = 1'b0;
        step();
        chk_idle("idle_after_reset");

        foreach (vecs[i]) begin
            load_idle(vecs[i].digits);
            bus.enable = 1'b1;
            run_frame($sformatf("vec%0d", i), vecs[i].seg, 30, 0, '0);
            bus.enable = 1'b0;
            step();
            chk_idle($sformatf("vec%0d_off", i));
        end

        // Mid-frame load during digit 2 is held until the frame boundary.
        load_idle(24'h001234);
        bus.enable = 1'b1;
        run_frame("midload_f1", SEG_1234, 30, 13, 24'h888888);
        run_frame("midload_f2", SEG_8, 30, 0, '0);

        // Load on the frame_done cycle goes straight to the display bank.
        run_frame("bndload", SEG_1234, 30, 1, 24'h001234);
        bus.enable = 1'b0;
        step();
        chk_idle("bndload_off");

        // Drop enable while digit 3 is shown.
        bus.enable = 1'b1;
        run_frame("drop", SEG_1234, 18, 0, '0);
        bus.enable = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            step();
            chk_idle($sformatf("drop_idle%0d", k));
        end
        bus.enable = 1'b1;
        run_frame("reenable", SEG_1234, 30, 0, '0);

        // Reset mid-frame wins over a coincident load and enable.
        run_frame("prereset", SEG_1234, 12, 0, '0);
        rst      = 1'b1;
        bus.load = 1'b1;
        set_inputs(24'h888888);
        step();
        chk_idle("reset_mid");
        rst      = 1'b0;
        bus.load = 1'b0;
        run_frame("post_reset", SEG_ZERO, 30, 0, '0);
        bus.enable = 1'b0;
        step();
        chk_idle("final_off");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
